// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one data memory between CORES requesting cores.
// One transaction at a time: IDLE -> ACCESS -> (WAIT for loads) -> ACK.
// Build option: define DM_ARBITER_FIXED_PRIO_EN for fixed lowest-index
// priority; when undefined (default) the grant is round-robin.
module dm_arbiter #(
  parameter int CORES  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CORES-1:0]          req,
  input  logic [CORES-1:0]          we,
  input  logic [CORES*ADDR_W-1:0]   addr,
  input  logic [CORES*DATA_W-1:0]   wdata,
  output logic [CORES-1:0]          ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int unsigned NC    = CORES;
  localparam int unsigned IDX_W = (CORES > 1) ? $clog2(CORES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WAIT,
    S_ACK
  } state_t;

  state_t              r_state;
  logic [IDX_W-1:0]    r_owner;
  logic [CORES-1:0]    r_ack;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
`ifndef DM_ARBITER_FIXED_PRIO_EN
  logic [IDX_W-1:0]    r_last;
  logic [IDX_W-1:0]    w_cand;
`endif

  logic [CORES-1:0]    w_owner_oh;
  logic [CORES-1:0]    w_pending;
  logic                w_win_valid;
  logic [IDX_W-1:0]    w_win_idx;
  logic                w_win_we;
  logic [ADDR_W-1:0]   w_win_addr;
  logic [DATA_W-1:0]   w_win_wdata;

  // Owner one-hot; the owner's still-high req is masked while it is being acked
  always_comb begin
    w_owner_oh = '0;
    for (int i = 0; i < CORES; i++) begin
      w_owner_oh[i] = (r_owner == IDX_W'(i));
    end
    w_pending = (r_state == S_ACK) ? (req & ~w_owner_oh) : req;
  end

`ifdef DM_ARBITER_FIXED_PRIO_EN
  // Fixed priority: lowest-index pending core wins
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    for (int i = CORES - 1; i >= 0; i--) begin
      if (w_pending[i]) begin
        w_win_valid = 1'b1;
        w_win_idx   = IDX_W'(i);
      end
    end
  end
`else
  // Round-robin: search starts one past the last owner and wraps
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int unsigned k = 1; k <= NC; k++) begin
      w_cand = IDX_W'((32'(r_last) + k) % NC);
      if (!w_win_valid && w_pending[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end
`endif

  // Select the winner's command fields out of the flattened buses
  always_comb begin
    w_win_we    = 1'b0;
    w_win_addr  = '0;
    w_win_wdata = '0;
    for (int i = 0; i < CORES; i++) begin
      if (w_win_idx == IDX_W'(i)) begin
        w_win_we    = we[i];
        w_win_addr  = addr[i*ADDR_W +: ADDR_W];
        w_win_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Transaction FSM with registered strobes, ack and load data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
`ifndef DM_ARBITER_FIXED_PRIO_EN
      r_last      <= IDX_W'(NC - 1);
`endif
    end else begin
      r_ack       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      case (r_state)
        S_IDLE, S_ACK: begin
          if (w_win_valid) begin
            r_owner     <= w_win_idx;
`ifndef DM_ARBITER_FIXED_PRIO_EN
            r_last      <= w_win_idx;
`endif
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_win_we;
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
            r_state     <= S_ACCESS;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACCESS: begin
          if (r_mem_we) begin
            r_ack   <= w_owner_oh;
            r_state <= S_ACK;
          end else begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_rdata <= mem_rdata;
          r_ack   <= w_owner_oh;
          r_state <= S_ACK;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
